// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 cache port between the L1 I-cache and D-cache.
// The winning request is latched at grant and held toward L2 until l2_mem_resp.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              l2_mem_read,
  output logic              l2_mem_write,
  output logic [ADDR_W-1:0] l2_mem_address,
  output logic [LINE_W-1:0] l2_mem_wdata,
  input  logic              l2_mem_resp,
  input  logic [LINE_W-1:0] l2_mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state_r;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              rd_r;
  logic              wr_r;
  logic              d_req_s;
  logic              grant_i_s;
  logic              grant_d_s;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    d_req_s   = d_mem_read | d_mem_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (i_mem_read && (!d_req_s || last_grant_r)) begin
      grant_i_s = 1'b1;
    end else if (d_req_s) begin
      grant_d_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
    end
  end

  // Arbitration FSM; the latched op/address/data registers double as the L2 outputs
  // and are cleared whenever no transaction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {LINE_W{1'b0}};
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_i_s) begin
            state_r      <= SERVE_I;
            last_grant_r <= 1'b0;
            addr_r       <= i_mem_address;
            wdata_r      <= {LINE_W{1'b0}};
            rd_r         <= 1'b1;
            wr_r         <= 1'b0;
          end else if (grant_d_s) begin
            state_r      <= SERVE_D;
            last_grant_r <= 1'b1;
            addr_r       <= d_mem_address;
            wdata_r      <= d_mem_wdata;
            // read+write together is treated as a write
            rd_r         <= ~d_mem_write;
            wr_r         <= d_mem_write;
          end else begin
            state_r <= IDLE;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_mem_resp) begin
            state_r <= DONE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {LINE_W{1'b0}};
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          addr_r  <= {ADDR_W{1'b0}};
          wdata_r <= {LINE_W{1'b0}};
          rd_r    <= 1'b0;
          wr_r    <= 1'b0;
        end
      endcase
    end
  end

  assign l2_mem_read    = rd_r;
  assign l2_mem_write   = wr_r;
  assign l2_mem_address = addr_r;
  assign l2_mem_wdata   = wdata_r;

  // Responses forward combinationally so the L1 sees them in the L2 response cycle.
  assign i_mem_resp  = (state_r == SERVE_I) & l2_mem_resp;
  assign d_mem_resp  = (state_r == SERVE_D) & l2_mem_resp;
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed vector table, hand sequences for alternation and
// async reset, then random traffic checked against a transaction-level model.
module tb_l2_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;
  localparam logic [LW-1:0] Z    = 128'h0;
  localparam logic [LW-1:0] LDB  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [LW-1:0] LA   = 128'hA5A5_A5A5_0101_0202_0303_0404_A5A5_A5A5;
  localparam logic [LW-1:0] LB   = 128'h5A5A_5A5A_F0F0_E0E0_D0D0_C0C0_5A5A_5A5A;
  localparam logic [LW-1:0] LC   = 128'hC0DE_CAFE_1234_5678_9ABC_DEF0_0F0F_F0F0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_mem_read, d_mem_read, d_mem_write, l2_mem_resp;
  logic [AW-1:0] i_mem_address, d_mem_address;
  logic [LW-1:0] d_mem_wdata, l2_mem_rdata;
  logic          i_mem_resp, d_mem_resp, l2_mem_read, l2_mem_write;
  logic [LW-1:0] i_mem_rdata, d_mem_rdata, l2_mem_wdata;
  logic [AW-1:0] l2_mem_address;

  int checks = 0;
  int failures = 0;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .l2_mem_read(l2_mem_read), .l2_mem_write(l2_mem_write),
    .l2_mem_address(l2_mem_address), .l2_mem_wdata(l2_mem_wdata),
    .l2_mem_resp(l2_mem_resp), .l2_mem_rdata(l2_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic          d_rd, d_wr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic          l2_resp;
    logic [LW-1:0] l2_rdata;
    logic          e_rd, e_wr, e_iresp, e_dresp;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic ir, logic [AW-1:0] ia, logic dr, logic dw,
                              logic [AW-1:0] da, logic [LW-1:0] dd, logic lr,
                              logic [LW-1:0] ld, logic er, logic ew, logic ei,
                              logic ed, logic [AW-1:0] ea, logic [LW-1:0] ewd);
    vec_t v;
    v.i_rd = ir; v.i_addr = ia; v.d_rd = dr; v.d_wr = dw; v.d_addr = da;
    v.d_wdata = dd; v.l2_resp = lr; v.l2_rdata = ld; v.e_rd = er; v.e_wr = ew;
    v.e_iresp = ei; v.e_dresp = ed; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] outs();
    return {12'h0, l2_mem_read, l2_mem_write, i_mem_resp, d_mem_resp,
            l2_mem_address, l2_mem_wdata};
  endfunction

  function automatic logic [159:0] want(logic r, logic w, logic ir, logic dr,
                                        logic [AW-1:0] a, logic [LW-1:0] d);
    return {12'h0, r, w, ir, dr, a, d};
  endfunction

  task automatic clear_inputs();
    i_mem_read = 1'b0; i_mem_address = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_wdata = '0;
    l2_mem_resp = 1'b0; l2_mem_rdata = '0;
  endtask

  // Leaves the bench just after a falling edge with the DUT in IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    i_mem_read = v.i_rd; i_mem_address = v.i_addr;
    d_mem_read = v.d_rd; d_mem_write = v.d_wr;
    d_mem_address = v.d_addr; d_mem_wdata = v.d_wdata;
    l2_mem_resp = v.l2_resp; l2_mem_rdata = v.l2_rdata;
  endtask

  // Transaction-level reference: who owns the L2 port and what was captured at grant.
  int            m_owner;
  bit            m_dead, m_last, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    i_mem_read = 1'b1; i_mem_address = 16'h1230; l2_mem_resp = 1'b1; l2_mem_rdata = LA;
    #2;
    chk("reset_outputs", outs(), want(0, 0, 0, 0, 16'h0, Z));
    do_reset();
    chk("post_reset_idle", outs(), want(0, 0, 0, 0, 16'h0, Z));

    tbl[0]  = mk(1, 16'h1230, 0, 0, 16'h0, Z, 0, Z,   0, 0, 0, 0, 16'h0, Z);
    tbl[1]  = mk(1, 16'h1230, 0, 0, 16'h0, Z, 0, Z,   1, 0, 0, 0, 16'h1230, Z);
    tbl[2]  = mk(1, 16'h1230, 0, 0, 16'h0, Z, 1, LDB, 1, 0, 1, 0, 16'h1230, Z);
    tbl[3]  = mk(1, 16'h1230, 0, 0, 16'h0, Z, 1, LDB, 0, 0, 0, 0, 16'h0, Z);
    tbl[4]  = mk(0, 16'h0, 0, 1, 16'h4000, LA, 0, Z,  0, 0, 0, 0, 16'h0, Z);
    tbl[5]  = mk(0, 16'h0, 0, 1, 16'h4000, LB, 0, Z,  0, 1, 0, 0, 16'h4000, LA);
    tbl[6]  = mk(0, 16'h0, 0, 1, 16'h4000, LB, 1, LC, 0, 1, 0, 1, 16'h4000, LA);
    tbl[7]  = mk(0, 16'h0, 0, 0, 16'h0, Z, 0, Z,      0, 0, 0, 0, 16'h0, Z);
    tbl[8]  = mk(0, 16'h0, 1, 1, 16'h5000, LC, 1, LDB, 0, 0, 0, 0, 16'h0, Z);
    tbl[9]  = mk(0, 16'h0, 0, 0, 16'h0, Z, 0, Z,      0, 1, 0, 0, 16'h5000, LC);
    tbl[10] = mk(0, 16'h0, 0, 0, 16'h0, Z, 1, LA,     0, 1, 0, 1, 16'h5000, LC);
    tbl[11] = mk(0, 16'h0, 0, 0, 16'h0, Z, 0, Z,      0, 0, 0, 0, 16'h0, Z);
    tbl[12] = mk(1, 16'h2222, 1, 0, 16'h3333, Z, 0, Z, 0, 0, 0, 0, 16'h0, Z);
    tbl[13] = mk(0, 16'h0, 1, 0, 16'h3333, Z, 0, Z,   1, 0, 0, 0, 16'h2222, Z);
    tbl[14] = mk(0, 16'h0, 1, 0, 16'h3333, Z, 1, LB,  1, 0, 1, 0, 16'h2222, Z);
    tbl[15] = mk(0, 16'h0, 1, 0, 16'h3333, Z, 0, Z,   0, 0, 0, 0, 16'h0, Z);
    tbl[16] = mk(0, 16'h0, 1, 0, 16'h3333, Z, 0, Z,   0, 0, 0, 0, 16'h0, Z);
    tbl[17] = mk(0, 16'h0, 1, 0, 16'h3333, Z, 1, LDB, 1, 0, 0, 1, 16'h3333, Z);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d", i), outs(),
          want(tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_iresp, tbl[i].e_dresp,
               tbl[i].e_addr, tbl[i].e_wdata));
      if (tbl[i].e_iresp) chk($sformatf("row%0d_irdata", i), {32'h0, i_mem_rdata}, {32'h0, tbl[i].l2_rdata});
      if (tbl[i].e_dresp) chk($sformatf("row%0d_drdata", i), {32'h0, d_mem_rdata}, {32'h0, tbl[i].l2_rdata});
      @(negedge clk);
    end

    // Both requesters held from reset: grants must alternate D, I, D, I.
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 16'h1111;
    d_mem_read = 1'b1; d_mem_address = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      l2_mem_resp = 1'b1;
      #1;
      chk($sformatf("alt%0d", k), outs(),
          want(1, 0, k % 2 == 1, k % 2 == 0, (k % 2 == 0) ? 16'h2222 : 16'h1111, Z));
      @(negedge clk);
      l2_mem_resp = 1'b0;
      @(negedge clk);
    end

    // Async reset in the middle of a D write, then a pending I read is granted.
    do_reset();
    d_mem_write = 1'b1; d_mem_address = 16'h4000; d_mem_wdata = LA;
    @(negedge clk);
    #1;
    chk("arst_pre", outs(), want(0, 1, 0, 0, 16'h4000, LA));
    rst_n = 1'b0;
    l2_mem_resp = 1'b1;
    #1;
    chk("arst_during", outs(), want(0, 0, 0, 0, 16'h0, Z));
    clear_inputs();
    i_mem_read = 1'b1; i_mem_address = 16'h1230;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("arst_after", outs(), want(1, 0, 0, 0, 16'h1230, Z));

    // Random traffic against the transaction model.
    do_reset();
    m_owner = -1; m_dead = 1'b0; m_last = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      int w;
      i_mem_read    = ($urandom_range(0, 3) != 0);
      i_mem_address = AW'($urandom);
      d_mem_read    = $urandom_range(0, 1) == 1;
      d_mem_write   = $urandom_range(0, 2) == 0;
      d_mem_address = AW'($urandom);
      d_mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      l2_mem_resp   = $urandom_range(0, 2) == 0;
      l2_mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk($sformatf("rand%0d", c), outs(),
          want(m_owner >= 0 && !m_wr, m_owner >= 0 && m_wr,
               m_owner == 0 && l2_mem_resp, m_owner == 1 && l2_mem_resp,
               (m_owner >= 0) ? m_addr : 16'h0, (m_owner >= 0) ? m_wdata : Z));
      if (m_owner == 0 && l2_mem_resp) chk($sformatf("rand%0d_irdata", c), {32'h0, i_mem_rdata}, {32'h0, l2_mem_rdata});
      if (m_owner == 1 && l2_mem_resp) chk($sformatf("rand%0d_drdata", c), {32'h0, d_mem_rdata}, {32'h0, l2_mem_rdata});
      if (m_owner >= 0) begin
        if (l2_mem_resp) begin
          m_owner = -1;
          m_dead  = 1'b1;
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else begin
        if (i_mem_read && (d_mem_read || d_mem_write)) w = m_last ? 0 : 1;
        else if (i_mem_read) w = 0;
        else if (d_mem_read || d_mem_write) w = 1;
        else w = -1;
        if (w >= 0) begin
          m_owner = w;
          m_last  = (w == 1);
          m_addr  = (w == 1) ? d_mem_address : i_mem_address;
          m_wdata = (w == 1) ? d_mem_wdata : Z;
          m_wr    = (w == 1) && d_mem_write;
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single L2 cache port between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Sits between the two L1 controllers and the L2 cache's mem_read/mem_write/mem_address/mem_wdata/mem_rdata/mem_resp interface.
- Grants one requester at a time with round-robin arbitration.
- Latches the granted request and holds it stable toward L2 until mem_resp.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, cacheline width (lc3b_cacheline).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_mem_read  in  1  I-cache line read request, level, held until i_mem_resp.
- i_mem_address  in  ADDR_W  I-cache line address.
- i_mem_resp  out  1  I-cache response, one-cycle pulse.
- i_mem_rdata  out  LINE_W  line returned to I-cache.
- d_mem_read  in  1  D-cache line read request.
- d_mem_write  in  1  D-cache line write request.
- d_mem_address  in  ADDR_W  D-cache line address.
- d_mem_wdata  in  LINE_W  D-cache write line.
- d_mem_resp  out  1  D-cache response, one-cycle pulse.
- d_mem_rdata  out  LINE_W  line returned to D-cache.
- l2_mem_read  out  1  read request to L2.
- l2_mem_write  out  1  write request to L2.
- l2_mem_address  out  ADDR_W  latched address to L2.
- l2_mem_wdata  out  LINE_W  latched write data to L2.
- l2_mem_resp  in  1  L2 completion, one-cycle pulse.
- l2_mem_rdata  in  LINE_W  L2 read line, valid with l2_mem_resp.

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- last_grant register (0=I, 1=D) drives round-robin; reset value 0, so D wins the first tie.
- Reset (async, rst_n=0):
  - State goes to IDLE, last_grant=0.
  - Latched addr/wdata/op regs clear to 0.
  - All outputs go to 0 immediately: l2_mem_read/write, i_/d_mem_resp, address, wdata.
- IDLE:
  - Only i request pending: go to SERVE_I.
  - Only d request (read or write) pending: go to SERVE_D.
  - Both pending: grant the requester not equal to last_grant.
  - On grant, latch address, wdata (D only) and op, and update last_grant.
  - Outputs are all 0 while in IDLE.
- SERVE_I / SERVE_D:
  - l2_mem_read/l2_mem_write driven from the latched op; l2_mem_address/l2_mem_wdata driven from latched regs.
  - A requester's input changes after grant have no effect.
  - On l2_mem_resp=1: pulse the granted requester's *_mem_resp in the same cycle (combinational), with *_mem_rdata = l2_mem_rdata. Go to DONE at the next edge.
- DONE:
  - One dead cycle, all outputs 0, lets the L1 deassert its request; then go to IDLE.
  - A request still asserted in DONE is not sampled.
- Latency: request seen in cycle 0 (IDLE) → L2 request asserted cycle 1 → L1 resp in the same cycle as l2_mem_resp. Minimum request-to-request spacing is 3 cycles plus L2 latency.
- d_mem_read and d_mem_write both high: treat as write (latched op = write, l2_mem_read=0).
- l2_mem_read and l2_mem_write are never both 1.
- Requester drops its request before resp (protocol violation):
  - Transaction still completes to L2.
  - The resp pulse is still issued; the L1 ignores it.
- l2_mem_resp outside SERVE_*: ignored, no L1 resp.
- The non-granted requester's resp is always 0.
- *_mem_rdata may pass l2_mem_rdata through at all times; it is only meaningful with resp.
- Starvation bound: a pending requester is granted no later than after one transaction of the other.

Test Plan:
- Reset then single I read 0x1230 → cycle 1: l2_mem_read=1, l2_mem_address=0x1230. L2 resp with line 0xDEAD…BEEF → i_mem_resp=1 same cycle, i_mem_rdata matches, d_mem_resp=0. Then DONE, then IDLE.
- D write 0x4000 with wdata pattern A → l2_mem_write=1, l2_mem_wdata=A held stable even if d_mem_wdata changes to B mid-transaction. d_mem_resp pulses on l2_mem_resp.
- I and D request simultaneously from reset → D served first, then I. Both held continuously → grants alternate D, I, D, I.
- Async reset asserted mid SERVE_D (L2 not yet responded) → l2_mem_write=0 immediately. After release the FSM is in IDLE and a pending I read is granted.
- d_mem_read=d_mem_write=1 → only l2_mem_write=1. Spurious l2_mem_resp in IDLE → no i_/d_mem_resp.
- I drops i_mem_read mid-service → l2_mem_read stays 1 until l2_mem_resp, then the FSM returns to IDLE normally.
